gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 122 ++++++++++++
 tb/tb_gshare_predictor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: PC-xor-history indexed table of saturating counters,
// a speculative global history register with mispredict repair, and a clear sweep.
module gshare_predictor #(
    parameter int IDX_W     = 6,
    parameter int CTR_W     = 2,
    parameter int HIST_W    = 6,
    parameter int RESET_CTR = 2**(CTR_W-1)-1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              lk_valid,
    input  logic [31:0]       lk_pc,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_taken,
    input  logic              upd_mispred,
    input  logic              clear,
    output logic              ready
);

    localparam int DEPTH = 2**IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(RESET_CTR);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [IDX_W-1:0]  sweep_ptr;
    logic [HIST_W-1:0] ghr;
    logic [CTR_W-1:0]  ctr_tbl [DEPTH];

    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic              in_idle;
    logic              unused_pc_bits;

    function automatic logic [IDX_W-1:0] table_index(input logic [IDX_W-1:0] pc_bits,
                                                     input logic [HIST_W-1:0] hist);
        return pc_bits ^ IDX_W'(hist);
    endfunction

    // Shift a new outcome into bit 0; also covers HIST_W == 1.
    function automatic logic [HIST_W-1:0] hist_shift(input logic [HIST_W-1:0] hist,
                                                     input logic bit_in);
        logic [HIST_W-1:0] r;
        r    = hist << 1;
        r[0] = bit_in;
        return r;
    endfunction

    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] ctr,
                                                  input logic up);
        logic [CTR_W-1:0] r;
        r = ctr;
        if (up) begin
            if (ctr != CTR_MAX) r = ctr + 1'b1;
        end else begin
            if (ctr != '0) r = ctr - 1'b1;
        end
        return r;
    endfunction

    assign in_idle = (state == IDLE);
    assign lk_idx  = table_index(lk_pc[IDX_W+1:2], ghr);
    assign upd_idx = table_index(upd_pc[IDX_W+1:2], upd_hist);

    assign pred_taken = in_idle & ctr_tbl[lk_idx][CTR_W-1];
    assign pred_hist  = ghr;
    assign ready      = in_idle;

    assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0],
                              upd_pc[31:IDX_W+2], upd_pc[1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sweep_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state     <= CLEAR;
                        sweep_ptr <= '0;
                    end
                end
                CLEAR: begin
                    sweep_ptr <= sweep_ptr + 1'b1;
                    if (sweep_ptr == LAST_IDX) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mispredict repair takes priority over the speculative lookup shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ghr <= '0;
        end else if (!in_idle || clear) begin
            ghr <= '0;
        end else if (upd_valid && upd_mispred) begin
            ghr <= hist_shift(upd_hist, upd_taken);
        end else if (lk_valid) begin
            ghr <= hist_shift(ghr, pred_taken);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) ctr_tbl[i] <= CTR_INIT;
        end else if (!in_idle) begin
            ctr_tbl[sweep_ptr] <= CTR_INIT;
        end else if (upd_valid) begin
            ctr_tbl[upd_idx] <= sat_step(ctr_tbl[upd_idx], upd_taken);
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor at IDX_W=4, CTR_W=2, HIST_W=4, RESET_CTR=1.
module tb_gshare_predictor;

    localparam int IDX_W = 4;
    localparam int HIST_W = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              lk_valid = 1'b0;
    logic [31:0]       lk_pc = '0;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_hist;
    logic              upd_valid = 1'b0;
    logic [31:0]       upd_pc = '0;
    logic [HIST_W-1:0] upd_hist = '0;
    logic              upd_taken = 1'b0;
    logic              upd_mispred = 1'b0;
    logic              clear = 1'b0;
    logic              ready;

    int n_vec = 0;
    int n_err = 0;

    gshare_predictor #(.IDX_W(4), .CTR_W(2), .HIST_W(4), .RESET_CTR(1)) dut (
        .clk(clk), .rstn(rstn),
        .lk_valid(lk_valid), .lk_pc(lk_pc),
        .pred_taken(pred_taken), .pred_hist(pred_hist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred),
        .clear(clear), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lkv;
        logic [31:0] lkpc;
        logic        uv;
        logic [31:0] upc;
        logic [3:0]  uh;
        logic        ut;
        logic        um;
        logic        e_pt;
        logic [3:0]  e_ph;
        logic        e_rdy;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_ctrs(input string name);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s ctr[%0d]", name, i), 32'(dut.ctr_tbl[i]), 32'd1);
    endtask

    task automatic idle_inputs();
        lk_valid = 0; upd_valid = 0; upd_mispred = 0; upd_taken = 0; clear = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // lkv lkpc    uv upc    uh ut um  pt ph  rdy
        vecs[0]  = '{0, 32'h10, 0, 32'h00, 0, 0, 0, 0, 4'h0, 1};
        vecs[1]  = '{0, 32'h10, 1, 32'h10, 0, 1, 0, 0, 4'h0, 1};
        vecs[2]  = '{0, 32'h10, 1, 32'h10, 0, 1, 0, 1, 4'h0, 1};
        vecs[3]  = '{0, 32'h10, 1, 32'h10, 0, 1, 0, 1, 4'h0, 1};
        vecs[4]  = '{0, 32'h10, 0, 32'h00, 0, 0, 0, 1, 4'h0, 1};
        vecs[5]  = '{1, 32'h10, 0, 32'h00, 0, 0, 0, 1, 4'h0, 1};
        vecs[6]  = '{1, 32'h14, 0, 32'h00, 0, 0, 0, 1, 4'h1, 1};
        vecs[7]  = '{1, 32'h1C, 0, 32'h00, 0, 0, 0, 1, 4'h3, 1};
        vecs[8]  = '{1, 32'h0C, 0, 32'h00, 0, 0, 0, 1, 4'h7, 1};
        vecs[9]  = '{0, 32'h10, 0, 32'h00, 0, 0, 0, 0, 4'hF, 1};
        vecs[10] = '{0, 32'h2C, 0, 32'h00, 0, 0, 0, 1, 4'hF, 1};
        vecs[11] = '{0, 32'h10, 1, 32'h10, 4'hF, 1, 0, 0, 4'hF, 1};
        vecs[12] = '{0, 32'h10, 0, 32'h00, 0, 0, 0, 1, 4'hF, 1};
        vecs[13] = '{1, 32'h10, 1, 32'h00, 4'h5, 0, 1, 1, 4'hF, 1};
        vecs[14] = '{0, 32'h00, 0, 32'h00, 0, 0, 0, 0, 4'hA, 1};
        vecs[15] = '{0, 32'h00, 1, 32'h00, 4'h5, 0, 0, 0, 4'hA, 1};
        vecs[16] = '{0, 32'h00, 1, 32'h00, 4'h5, 1, 0, 0, 4'hA, 1};
        vecs[17] = '{0, 32'h3C, 0, 32'h00, 0, 0, 0, 0, 4'hA, 1};
        vecs[18] = '{0, 32'h00, 1, 32'h00, 4'h8, 1, 1, 0, 4'hA, 1};
        vecs[19] = '{0, 32'h00, 0, 32'h00, 0, 0, 0, 0, 4'h1, 1};
        vecs[20] = '{0, 32'h00, 0, 32'h00, 0, 0, 1, 0, 4'h1, 1};
        vecs[21] = '{0, 32'h24, 0, 32'h00, 0, 0, 0, 1, 4'h1, 1};

        lk_pc = 32'h10;
        #12;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset pred_hist", 32'(pred_hist), 32'd0);
        chk("reset pred_taken", 32'(pred_taken), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            lk_valid = vecs[v].lkv; lk_pc = vecs[v].lkpc;
            upd_valid = vecs[v].uv; upd_pc = vecs[v].upc; upd_hist = vecs[v].uh;
            upd_taken = vecs[v].ut; upd_mispred = vecs[v].um;
            #1;
            chk($sformatf("vec%0d pred_taken", v), 32'(pred_taken), 32'(vecs[v].e_pt));
            chk($sformatf("vec%0d pred_hist", v), 32'(pred_hist), 32'(vecs[v].e_ph));
            chk($sformatf("vec%0d ready", v), 32'(ready), 32'(vecs[v].e_rdy));
        end

        // Clear sweep with lookups and updates held high; second clear mid-sweep ignored.
        @(negedge clk);
        lk_valid = 1; lk_pc = 32'h24; upd_valid = 1; upd_pc = 32'h10;
        upd_hist = 0; upd_taken = 1; upd_mispred = 1; clear = 1;
        #1;
        chk("clear cycle ready", 32'(ready), 32'd1);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            clear = (c == 5);
            #1;
            chk($sformatf("sweep%0d ready", c), 32'(ready), 32'd0);
            chk($sformatf("sweep%0d pred_taken", c), 32'(pred_taken), 32'd0);
            chk($sformatf("sweep%0d pred_hist", c), 32'(pred_hist), 32'd0);
        end
        @(negedge clk);
        clear = 0;
        #1;
        chk("post sweep ready", 32'(ready), 32'd1);
        chk("post sweep pred_hist", 32'(pred_hist), 32'd0);
        chk_all_ctrs("post sweep");
        idle_inputs();

        // Train entry 12 to strongly taken, then reset in the middle of a sweep.
        @(negedge clk);
        upd_valid = 1; upd_pc = 32'h30; upd_hist = 0; upd_taken = 1;
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        lk_pc = 32'h30;
        #1;
        chk("trained entry12", 32'(pred_taken), 32'd1);
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        for (int c = 1; c < 7; c++) @(negedge clk);
        #1;
        chk("mid sweep ready", 32'(ready), 32'd0);
        #1;
        rstn = 1'b0;
        #1;
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort pred_hist", 32'(pred_hist), 32'd0);
        chk("abort sweep_ptr", 32'(dut.sweep_ptr), 32'd0);
        chk_all_ctrs("abort");
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("after abort%0d ready", c), 32'(ready), 32'd1);
            chk($sformatf("after abort%0d pred_taken", c), 32'(pred_taken), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
